// File: rtl/aes_word_serializer.sv
// Splits one captured AES block into NUM_WORDS words on a valid/ready stream.
// Optional build macro AES_SER_LSW_FIRST_EN reverses emission order (LSW first).
module aes_word_serializer #(
  parameter  int unsigned WORD_W    = 32,
  parameter  int unsigned NUM_WORDS = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_WORDS),
  localparam int unsigned BLK_W     = WORD_W * NUM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BLK_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

`ifdef AES_SER_LSW_FIRST_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = '0;
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
`endif

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLK_W-1:0]   block_q, block_d;
  logic               is_last;
  logic               accept;
  logic               take;

  // Slot k sits at the k-th word counted from the MSB end of the block.
  function automatic logic [WORD_W-1:0] word_at(input logic [BLK_W-1:0] blk,
                                                input logic [IDX_W-1:0] k);
    word_at = blk[(NUM_WORDS - 1 - 32'(k)) * WORD_W +: WORD_W];
  endfunction

  function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] k);
`ifdef AES_SER_LSW_FIRST_EN
    idx_step = k - IDX_W'(1);
`else
    idx_step = k + IDX_W'(1);
`endif
  endfunction

  assign is_last  = (state_q == SEND) && (idx_q == LAST_IDX);
  // Combinational on out_ready so a new block can follow the last word back-to-back.
  assign in_ready = !reset && !clear &&
                    ((state_q == IDLE) || (out_ready && is_last));
  assign accept   = in_valid && in_ready;
  assign take     = (state_q == SEND) && out_ready;

  // Next-state, index and block capture
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    block_d = block_q;
    if (clear) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            block_d = in_data;
            idx_d   = FIRST_IDX;
            state_d = SEND;
          end
        end
        SEND: begin
          if (take) begin
            if (is_last) begin
              if (accept) begin
                block_d = in_data;
                idx_d   = FIRST_IDX;
              end else begin
                state_d = IDLE;
                idx_d   = '0;
              end
            end else begin
              idx_d = idx_step(idx_q);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State and registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      block_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      block_q   <= block_d;
      out_valid <= (state_d == SEND);
      busy      <= (state_d == SEND);
      out_data  <= (state_d == SEND) ? word_at(block_d, idx_d) : '0;
      out_index <= (state_d == SEND) ? idx_d : '0;
      out_last  <= (state_d == SEND) && (idx_d == LAST_IDX);
    end
  end

endmodule
